// File: rtl/sram1rw_core_if.sv
// Request/response bundle for sram1rw_core: byte address, active-low write-size select, write lanes, read row.
interface sram1rw_core_if #(
    parameter int W_WIDTH = 6,
    parameter int H_WIDTH = 10
);
    typedef logic [7:0] byte_t;

    logic [H_WIDTH+W_WIDTH-1:0] addr;
    logic [W_WIDTH:0]           web;
    byte_t                      ibyte [2**W_WIDTH];
    byte_t                      obyte [2**W_WIDTH];

    modport master (output addr, output web, output ibyte, input obyte);
    modport slave  (input addr, input web, input ibyte, output obyte);
endinterface

// File: rtl/sram1rw_core.sv
// sram1rw_core: single-port byte-lane SRAM, one access per cycle, full-row registered read (1-cycle latency).
// Optional macro SRAM1RW_WRITE_FIRST_EN: obyte shows the merged row on write cycles; default is read-first.
module sram1rw_core #(
    parameter int W_WIDTH = 6,
    parameter int H_WIDTH = 10
) (
    input logic           clk,
    input logic           rst,
    sram1rw_core_if.slave bus
);
    localparam int NB = 2**W_WIDTH;
    localparam int NR = 2**H_WIDTH;

    logic [7:0]         mem [NR][NB];
    logic [H_WIDTH-1:0] row;
    logic [W_WIDTH-1:0] off;
    logic               wr;
    int                 sz_log;
    logic [NB-1:0]      lane_we;
    logic [7:0]         old_row [NB];
    logic [7:0]         new_row [NB];

    assign row = bus.addr[H_WIDTH+W_WIDTH-1:W_WIDTH];
    assign off = bus.addr[W_WIDTH-1:0];

    // Ascending scan lets the highest cleared web bit (largest size) win.
    always_comb begin
        wr     = 1'b0;
        sz_log = 0;
        for (int b = 0; b <= W_WIDTH; b++) begin
            if (!bus.web[b]) begin
                wr     = 1'b1;
                sz_log = b;
            end
        end
    end

    // A lane is in the window when it shares the offset's bits above the size; this forces alignment down.
    always_comb begin
        for (int j = 0; j < NB; j++) begin
            lane_we[j] = wr && ((W_WIDTH'(j) >> sz_log) == (off >> sz_log));
            old_row[j] = mem[row][j];
            new_row[j] = lane_we[j] ? bus.ibyte[j] : old_row[j];
        end
    end

    // Array is never reset; writes are simply suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < NB; j++) begin
                if (lane_we[j]) mem[row][j] <= bus.ibyte[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NB; j++) bus.obyte[j] <= 8'h00;
        end else begin
            for (int j = 0; j < NB; j++) begin
`ifdef SRAM1RW_WRITE_FIRST_EN
                bus.obyte[j] <= new_row[j];
`else
                bus.obyte[j] <= old_row[j];
`endif
            end
        end
    end
endmodule

// File: tb/tb_sram1rw_core.sv
// Randomized self-checking bench for sram1rw_core against a byte-array reference model.
module tb_sram1rw_core;
    localparam int W = 6;
    localparam int H = 10;
    localparam int NB = 64;
    localparam int NR = 1024;

    logic clk;
    logic rst;
    sram1rw_core_if #(.W_WIDTH(W), .H_WIDTH(H)) bus ();

    sram1rw_core #(.W_WIDTH(W), .H_WIDTH(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mref [NR][NB];
    bit         kn   [NR][NB];
    logic [7:0] din  [NB];
    int         n_cmp = 0;
    int         n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic fill_rand();
        for (int j = 0; j < NB; j++) din[j] = 8'($urandom);
    endtask

    task automatic fill_idx();
        for (int j = 0; j < NB; j++) din[j] = 8'(j);
    endtask

    task automatic chk_zero(input string tag);
        for (int j = 0; j < NB; j++) chk($sformatf("%s b%0d", tag, j), bus.obyte[j], 8'h00);
    endtask

    // One access: drive at negedge, check obyte just after the rising edge, then update the model.
    task automatic cyc(input logic [15:0] a, input logic [6:0] w);
        int r, o, sz, base;
        bit wr;
        logic [7:0] ex [NB];
        bit exk [NB];
        @(negedge clk);
        bus.addr = a;
        bus.web  = w;
        for (int j = 0; j < NB; j++) bus.ibyte[j] = din[j];
        r = int'(a) / NB;
        o = int'(a) % NB;
        wr = 0;
        sz = 1;
        for (int k = 6; k >= 0; k--) begin
            if (!wr && !w[k]) begin
                wr = 1;
                sz = 1 << k;
            end
        end
        base = (o / sz) * sz;
        for (int j = 0; j < NB; j++) begin
            ex[j]  = mref[r][j];
            exk[j] = kn[r][j];
        end
        @(posedge clk);
        #1;
        if (wr) begin
            for (int j = base; j < base + sz; j++) begin
                mref[r][j] = din[j];
                kn[r][j]   = 1;
            end
        end
`ifdef SRAM1RW_WRITE_FIRST_EN
        for (int j = 0; j < NB; j++) begin
            ex[j]  = mref[r][j];
            exk[j] = kn[r][j];
        end
`endif
        for (int j = 0; j < NB; j++) begin
            if (exk[j]) chk($sformatf("rd r%0h b%0d", r, j), bus.obyte[j], ex[j]);
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [6:0]  w;
        int          r;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < NB; j++) kn[i][j] = 0;
        rst = 1'b0;
        bus.addr = '0;
        bus.web  = '1;
        for (int j = 0; j < NB; j++) bus.ibyte[j] = 8'h00;

        #1 rst = 1'b1;
        #2 chk_zero("rst0");
        repeat (2) @(posedge clk);
        #1 chk_zero("rst1");
        @(negedge clk);
        rst = 1'b0;

        fill_rand(); cyc(16'h00C0, 7'b0111111);
        fill_rand(); cyc(16'hCCC0, 7'b0111111);

        // Row 3 directed sequence, then the same at row 0x333.
        for (int pass = 0; pass < 2; pass++) begin
            logic [15:0] hi;
            hi = (pass == 0) ? 16'h0000 : 16'hCC00;
            fill_idx();  cyc(hi | 16'h00F8, 7'b1111011);
            cyc(hi | 16'h00C0, 7'b1111111);
            fill_idx();  cyc(hi | 16'h00C0, 7'b0111111);
            cyc(hi | 16'h00C0, 7'b1111111);
            fill_rand(); cyc(hi | 16'h00EA, 7'b1111101);
            cyc(hi | 16'h00C0, 7'b1111111);
            fill_rand(); cyc(hi | 16'h00EB, 7'b1111101);
            cyc(hi | 16'h00C0, 7'b1111111);
        end
        cyc(16'h00C0, 7'b1111111);

        // Mixed sizes: largest wins.
        fill_rand(); cyc(16'h00D5, 7'b0111101);
        cyc(16'h00C0, 7'b1111111);

        // Reset asserted mid-cycle while a write is presented.
        @(negedge clk);
        fill_rand();
        bus.addr = 16'h00C0;
        bus.web  = 7'b0111111;
        for (int j = 0; j < NB; j++) bus.ibyte[j] = din[j];
        #1 rst = 1'b1;
        #1 chk_zero("rst_async");
        @(posedge clk);
        #1 chk_zero("rst_hold");
        bus.web = '1;
        @(negedge clk);
        rst = 1'b0;
        cyc(16'h00C0, 7'b1111111);

        for (int n = 0; n < 400; n++) begin
            fill_rand();
            case ($urandom_range(0, 3))
                0: r = 3;
                1: r = 'h333;
                default: r = int'($urandom_range(0, 7));
            endcase
            a = 16'(r * NB + int'($urandom_range(0, NB - 1)));
            w = ($urandom_range(0, 2) == 0) ? 7'h7F : 7'($urandom);
            cyc(a, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
